shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 115 +++++++++++
 tb/tb_shift_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle 64-bit barrel-free shifter: one 1-bit or 8-bit step per clock,
// with a valid/ready command port, a held result port, flush and async reset.
module shift_sequencer #(
  parameter bit BYTE_STEP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        flush,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_data,
  input  logic [5:0]  cmd_count,
  input  logic        cmd_dir,
  input  logic        cmd_arith,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic [6:0]  res_steps,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_next;
  logic [63:0] q, q_step;
  logic [5:0]  remaining, rem_step;
  logic [6:0]  steps;
  logic        dir, arith;
  logic        ready_q;
  logic [63:0] res_data_q;
  logic [6:0]  res_steps_q;
  logic        accept;
  logic        big_step;

  assign accept = cmd_valid & ready_q;

  always_comb begin
    big_step = BYTE_STEP_EN && (remaining >= 6'd8);
    if (big_step) begin
      rem_step = remaining - 6'd8;
      if (dir) q_step = {{8{arith & q[63]}}, q[63:8]};
      else     q_step = {q[55:0], 8'h00};
    end else begin
      rem_step = remaining - 6'd1;
      if (dir) q_step = {arith & q[63], q[63:1]};
      else     q_step = {q[62:0], 1'b0};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = (cmd_count == 6'd0) ? DONE : SHIFT;
      SHIFT: begin
        if (flush)                 state_next = IDLE;
        else if (rem_step == 6'd0) state_next = DONE;
      end
      DONE:  if (flush || res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result registers load only on entry to DONE, so they keep the last
  // completed result while idle, shifting, or after a flush.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state       <= IDLE;
      ready_q     <= 1'b0;
      q           <= '0;
      remaining   <= '0;
      steps       <= '0;
      dir         <= 1'b0;
      arith       <= 1'b0;
      res_data_q  <= '0;
      res_steps_q <= '0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            q         <= cmd_data;
            remaining <= cmd_count;
            steps     <= '0;
            dir       <= cmd_dir;
            arith     <= cmd_arith;
            if (cmd_count == 6'd0) begin
              res_data_q  <= cmd_data;
              res_steps_q <= '0;
            end
          end
        end
        SHIFT: begin
          if (!flush) begin
            q         <= q_step;
            remaining <= rem_step;
            steps     <= steps + 7'd1;
            if (rem_step == 6'd0) begin
              res_data_q  <= q_step;
              res_steps_q <= steps + 7'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res_data  = res_data_q;
  assign res_steps = res_steps_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vectors plus random commands
// compared against an arithmetic shift model; a second instance covers 1-bit steps.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        flush = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [63:0] cmd_data = '0;
  logic [5:0]  cmd_count = '0;
  logic        cmd_dir = 1'b0;
  logic        cmd_arith = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic [6:0]  res_steps;
  logic        busy;

  logic        b_flush = 1'b0;
  logic        b_cmd_valid = 1'b0;
  logic        b_cmd_ready;
  logic [63:0] b_cmd_data = '0;
  logic [5:0]  b_cmd_count = '0;
  logic        b_cmd_dir = 1'b0;
  logic        b_cmd_arith = 1'b0;
  logic        b_res_valid;
  logic        b_res_ready = 1'b1;
  logic [63:0] b_res_data;
  logic [6:0]  b_res_steps;
  logic        b_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk(clk), .areset_n(areset_n), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_count(cmd_count), .cmd_dir(cmd_dir), .cmd_arith(cmd_arith),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_steps(res_steps), .busy(busy)
  );

  shift_sequencer #(.BYTE_STEP_EN(1'b0)) dut_bit (
    .clk(clk), .areset_n(areset_n), .flush(b_flush),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_data(b_cmd_data),
    .cmd_count(b_cmd_count), .cmd_dir(b_cmd_dir), .cmd_arith(b_cmd_arith),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_data(b_res_data),
    .res_steps(b_res_steps), .busy(b_busy)
  );

  function automatic logic [63:0] model_data(logic [63:0] d, int c, bit dr, bit ar);
    if (!dr)    return d << c;
    else if (ar) return $signed(d) >>> c;
    else        return d >> c;
  endfunction

  function automatic int model_steps(int c, bit byte_en);
    return byte_en ? (c / 8 + c % 8) : c;
  endfunction

  task automatic run_command(input logic [63:0] d, input int cnt, input bit dr,
                             input bit ar, input int bp, input string name);
    logic [63:0] exp_d;
    int exp_s, t, lat;
    exp_d = model_data(d, cnt, dr, ar);
    exp_s = model_steps(cnt, 1'b1);
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s ready_timeout: cmd_ready=%b required 1", name, cmd_ready);
      return;
    end
    cmd_valid = 1'b1; cmd_data = d; cmd_count = cnt[5:0]; cmd_dir = dr; cmd_arith = ar;
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_data = {$urandom, $urandom}; cmd_count = 6'($urandom);
    cmd_dir = 1'($urandom); cmd_arith = 1'($urandom);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("[TB] FAIL %s busy: got %b required 1", name, busy);
    end
    lat = 0;
    while (res_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    checks++;
    if (lat != exp_s) begin
      errors++; $display("[TB] FAIL %s latency: got %0d required %0d", name, lat, exp_s);
    end
    checks++;
    if (res_data !== exp_d) begin
      errors++; $display("[TB] FAIL %s data: got %h required %h", name, res_data, exp_d);
    end
    checks++;
    if (res_steps !== 7'(exp_s)) begin
      errors++; $display("[TB] FAIL %s steps: got %0d required %0d", name, res_steps, exp_s);
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp_d || res_steps !== 7'(exp_s) || cmd_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s hold: valid=%b data=%h steps=%0d ready=%b required 1 %h %0d 0",
                 name, res_valid, res_data, res_steps, cmd_ready, exp_d, exp_s);
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s release: valid=%b busy=%b ready=%b required 0 0 1",
               name, res_valid, busy, cmd_ready);
    end
    checks++;
    if (res_data !== exp_d) begin
      errors++; $display("[TB] FAIL %s held_data: got %h required %h", name, res_data, exp_d);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 ||
        res_data !== 64'h0 || res_steps !== 7'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: valid=%b busy=%b ready=%b data=%h steps=%0d required all 0",
               res_valid, busy, cmd_ready, res_data, res_steps);
    end
    @(negedge clk);
    areset_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready_before_edge: got %b required 0", cmd_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready_after_edge: got %b required 1", cmd_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_left_shift;
    run_command(64'h0000_0000_0000_00FF, 9, 1'b0, 1'b0, 0, "left9");
  endtask

  task automatic test_arith_right;
    run_command(64'h8000_0000_0000_0000, 12, 1'b1, 1'b1, 1, "arith12");
  endtask

  task automatic test_logical_right;
    run_command(64'h8000_0000_0000_0000, 63, 1'b1, 1'b0, 0, "logic63");
  endtask

  task automatic test_zero_backpressure;
    run_command(64'h1234_5678_9ABC_DEF0, 0, 1'b0, 1'b0, 3, "zero_bp");
  endtask

  task automatic test_flush;
    logic [63:0] d;
    bit seen;
    int t;
    // Flush while shifting a long command.
    cmd_valid = 1'b1; cmd_data = {$urandom, $urandom}; cmd_count = 6'd40; cmd_dir = 1'b0;
    res_ready = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_shift: busy=%b ready=%b valid=%b required 0 1 0", busy, cmd_ready, res_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("[TB] FAIL flush_no_result: activity=1 required 0");
    end
    // Flush while a zero-count result waits in DONE.
    d = {$urandom, $urandom};
    cmd_valid = 1'b1; cmd_data = d; cmd_count = 6'd0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || res_data !== d) begin
      errors++;
      $display("[TB] FAIL flush_done: valid=%b ready=%b data=%h required 0 1 %h", res_valid, cmd_ready, res_data, d);
    end
    // Flush in IDLE must not block an accept.
    d = {$urandom, $urandom};
    cmd_valid = 1'b1; cmd_data = d; cmd_count = 6'd5; cmd_dir = 1'b1; cmd_arith = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 begin cmd_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_idle_accept: busy=%b required 1", busy);
    end
    res_ready = 1'b1;
    t = 0;
    while (res_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (res_data !== model_data(d, 5, 1'b1, 1'b1)) begin
      errors++;
      $display("[TB] FAIL flush_idle_result: got %h required %h", res_data, model_data(d, 5, 1'b1, 1'b1));
    end
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      run_command({$urandom, $urandom}, int'($urandom_range(0, 63)), 1'($urandom),
                  1'($urandom), int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_bit_steps;
    logic [63:0] d, exp_d;
    int c, t, lat;
    bit dr, ar;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin d = 64'h8000_0000_0000_0000; c = 63; dr = 1'b1; ar = 1'b0; end
      else begin
        d = {$urandom, $urandom}; c = int'($urandom_range(0, 63));
        dr = 1'($urandom); ar = 1'($urandom);
      end
      exp_d = model_data(d, c, dr, ar);
      t = 0;
      while (b_cmd_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      b_cmd_valid = 1'b1; b_cmd_data = d; b_cmd_count = c[5:0]; b_cmd_dir = dr; b_cmd_arith = ar;
      @(posedge clk);
      #1 b_cmd_valid = 1'b0;
      @(negedge clk);
      lat = 0;
      while (b_res_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
      checks++;
      if (lat != c || b_res_data !== exp_d || b_res_steps !== 7'(c)) begin
        errors++;
        $display("[TB] FAIL bit_step: lat=%0d data=%h steps=%0d required %0d %h %0d",
                 lat, b_res_data, b_res_steps, c, exp_d, c);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_shift;
    bit seen;
    cmd_valid = 1'b1; cmd_data = {$urandom, $urandom}; cmd_count = 6'd63; cmd_dir = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 areset_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 ||
        res_data !== 64'h0 || res_steps !== 7'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid: valid=%b busy=%b ready=%b data=%h steps=%0d required all 0",
               res_valid, busy, cmd_ready, res_data, res_steps);
    end
    @(negedge clk);
    areset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_mid_ready: got %b required 1", cmd_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("[TB] FAIL reset_mid_abandon: activity=1 required 0");
    end
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_left_shift;
    test_arith_right;
    test_logical_right;
    test_zero_backpressure;
    test_flush;
    test_back_to_back;
    test_bit_steps;
    test_reset_mid_shift;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
